// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory-port arbiter (state, grant owner, widths).
package mem_arb_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 20;
  localparam int MAX_READ_LATENCY   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD_WR = 2'd1,
    CMD_RD = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_WR   = 2'd1,
    OWN_RD   = 2'd2
  } owner_t;

  // Writes win unless a read is waiting and the write burst budget is spent.
  function automatic owner_t pick_owner(input logic wr_req, input logic rd_req,
                                        input logic burst_full);
    if (wr_req && !(rd_req && burst_full)) return OWN_WR;
    if (rd_req) return OWN_RD;
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/rd_latency_pipe.sv
// Valid-bit shift register that tracks outstanding reads of a fixed-latency slave.
module rd_latency_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic flush,
  input  logic in_valid,
  output logic out_valid
);

  logic [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk) begin
    if (flush) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign out_valid = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one Avalon-MM master port between acc_recv writes and acc_send reads.
// Optional statistics counters are built only when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int READ_LATENCY = 1,
  parameter int MAX_WR_BURST = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_s,
  input  logic [ADDR_WIDTH-1:0] addr_s,
  output logic                  ack_s,
  output logic [DATA_WIDTH-1:0] rdata_s,
  output logic                  rvalid_s,
  input  logic                  write_r,
  input  logic [ADDR_WIDTH-1:0] write_addr_r,
  input  logic [DATA_WIDTH-1:0] data_to_mem_r,
  output logic                  ack_r,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  write,
  output logic                  read,
  output logic [DATA_WIDTH-1:0] writedata,
  input  logic [DATA_WIDTH-1:0] readdata,
  input  logic                  waitrequest,
  output logic                  chipselect,
  output logic [31:0]           stat_wr_cnt,
  output logic [31:0]           stat_rd_cnt,
  output logic [31:0]           stat_wait_cnt,
  output arb_state_t            dbg_state
);

  localparam int RD_LAT = (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                          (READ_LATENCY < 1) ? 1 : READ_LATENCY;
  localparam int BW = $clog2(MAX_WR_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_WR_BURST);

  // Handshake: a command is accepted in any cycle where state is CMD_* and
  // waitrequest is low; the owner's ack pulses in that cycle, and a request
  // still high at the end of that cycle is taken as the owner's next request.
  arb_state_t            state_q, state_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  read_d, write_d;
  logic                  accept, select_en;
  owner_t                winner;

  always_comb begin
    accept    = (state_q != IDLE) && !waitrequest;
    select_en = (state_q == IDLE) || accept;
    winner    = pick_owner(write_r, req_s, burst_q == BURST_MAX);
    ack_r     = accept && (state_q == CMD_WR);
    ack_s     = accept && (state_q == CMD_RD);
    state_d   = state_q;
    addr_d    = mem_addr;
    wdata_d   = writedata;
    read_d    = read;
    write_d   = write;
    burst_d   = burst_q;
    if (select_en) begin
      case (winner)
        OWN_WR: begin
          state_d = CMD_WR;
          addr_d  = write_addr_r;
          wdata_d = data_to_mem_r;
          write_d = 1'b1;
          read_d  = 1'b0;
          if (burst_q != BURST_MAX) burst_d = burst_q + 1'b1;
        end
        OWN_RD: begin
          state_d = CMD_RD;
          addr_d  = addr_s;
          write_d = 1'b0;
          read_d  = 1'b1;
          burst_d = '0;
        end
        default: begin
          state_d = IDLE;
          write_d = 1'b0;
          read_d  = 1'b0;
        end
      endcase
    end
    // The starvation guard only matters while a read is actually waiting.
    if (!req_s) burst_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      burst_q   <= '0;
      mem_addr  <= '0;
      writedata <= '0;
      read      <= 1'b0;
      write     <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      mem_addr  <= addr_d;
      writedata <= wdata_d;
      read      <= read_d;
      write     <= write_d;
    end
  end

  assign chipselect = read | write;
  assign dbg_state  = state_q;

  rd_latency_pipe #(.DEPTH(RD_LAT)) u_rd_pipe (
    .clk       (clk),
    .flush     (reset),
    .in_valid  (ack_s),
    .out_valid (rvalid_s)
  );

  assign rdata_s = rvalid_s ? readdata : '0;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] wr_cnt_q, rd_cnt_q, wait_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      if (ack_r) wr_cnt_q <= wr_cnt_q + 32'd1;
      if (ack_s) rd_cnt_q <= rd_cnt_q + 32'd1;
      if ((state_q != IDLE) && waitrequest) wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

  assign stat_wr_cnt   = wr_cnt_q;
  assign stat_rd_cnt   = rd_cnt_q;
  assign stat_wait_cnt = wait_cnt_q;
`else
  assign stat_wr_cnt   = '0;
  assign stat_rd_cnt   = '0;
  assign stat_wait_cnt = '0;
`endif

  // A requester may only drop its request in the cycle it is acknowledged.
  a_req_s_held: assert property (@(posedge clk) disable iff (reset)
    $fell(req_s) |-> (ack_s || $past(reset)));
  a_write_r_held: assert property (@(posedge clk) disable iff (reset)
    $fell(write_r) |-> (ack_r || $past(reset)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two instances (read latency 1 and 2) share stimulus.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 20;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- shared inputs ----------------
  logic          req_s = 1'b0, write_r = 1'b0, waitrequest = 1'b0;
  logic [AW-1:0] addr_s = '0, write_addr_r = '0;
  logic [DW-1:0] data_to_mem_r = '0;
  logic [DW-1:0] a_readdata, b_readdata;
  logic [AW-1:0] rd_p0 = '0, rd_p1 = '0;

  // ---------------- per-instance outputs ----------------
  logic          a_ack_s, a_rvalid_s, a_ack_r, a_write, a_read, a_chipselect;
  logic [DW-1:0] a_rdata_s, a_writedata;
  logic [AW-1:0] a_mem_addr;
  logic [31:0]   a_stat_wr, a_stat_rd, a_stat_wait;
  arb_state_t    a_dbg_state;
  logic          b_ack_s, b_rvalid_s, b_ack_r, b_write, b_read, b_chipselect;
  logic [DW-1:0] b_rdata_s, b_writedata;
  logic [AW-1:0] b_mem_addr;
  logic [31:0]   b_stat_wr, b_stat_rd, b_stat_wait;
  arb_state_t    b_dbg_state;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .MAX_WR_BURST(8)) dut_a (
    .clk(clk), .reset(reset), .req_s(req_s), .addr_s(addr_s), .ack_s(a_ack_s),
    .rdata_s(a_rdata_s), .rvalid_s(a_rvalid_s), .write_r(write_r), .write_addr_r(write_addr_r),
    .data_to_mem_r(data_to_mem_r), .ack_r(a_ack_r), .mem_addr(a_mem_addr), .write(a_write),
    .read(a_read), .writedata(a_writedata), .readdata(a_readdata), .waitrequest(waitrequest),
    .chipselect(a_chipselect), .stat_wr_cnt(a_stat_wr), .stat_rd_cnt(a_stat_rd),
    .stat_wait_cnt(a_stat_wait), .dbg_state(a_dbg_state)
  );

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .MAX_WR_BURST(8)) dut_b (
    .clk(clk), .reset(reset), .req_s(req_s), .addr_s(addr_s), .ack_s(b_ack_s),
    .rdata_s(b_rdata_s), .rvalid_s(b_rvalid_s), .write_r(write_r), .write_addr_r(write_addr_r),
    .data_to_mem_r(data_to_mem_r), .ack_r(b_ack_r), .mem_addr(b_mem_addr), .write(b_write),
    .read(b_read), .writedata(b_writedata), .readdata(b_readdata), .waitrequest(waitrequest),
    .chipselect(b_chipselect), .stat_wr_cnt(b_stat_wr), .stat_rd_cnt(b_stat_rd),
    .stat_wait_cnt(b_stat_wait), .dbg_state(b_dbg_state)
  );

  // Memory contents as seen by the reads.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 20'h00200) return 32'h12345678;
    return {12'hC0D, a};
  endfunction

  // Slave model: data for the address presented 1 (a) or 2 (b) cycles earlier.
  always @(posedge clk) begin
    rd_p0 <= a_mem_addr;
    rd_p1 <= rd_p0;
  end
  assign a_readdata = mem_word(rd_p0);
  assign b_readdata = mem_word(rd_p1);

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_pass = 0;
  int            cyc = 0;
  wr_t           wr_q[$];
  logic [AW-1:0] rd_q[$];
  logic [DW-1:0] a_exp_q[$], b_exp_q[$];
  int            a_due_q[$], b_due_q[$];
  logic          grant_log[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_reqs();
    write_r       = (wr_q.size() != 0);
    write_addr_r  = write_r ? wr_q[0].addr : '0;
    data_to_mem_r = write_r ? wr_q[0].data : '0;
    req_s         = (rd_q.size() != 0);
    addr_s        = req_s ? rd_q[0] : '0;
  endtask

  // One bus cycle: apply waitrequest, sample mid-cycle, score acks and returns,
  // then let the requesters react to their acks before the next edge.
  task automatic run_cycle(input logic stall);
    logic [DW-1:0] d;
    logic [AW-1:0] ra;
    int            due;
    wr_t           w;
    @(negedge clk);
    waitrequest = stall;
    #1;
    cyc++;
    ra = '0;
    if (a_rvalid_s) begin
      if (a_exp_q.size() == 0) check("a_rvalid_unexpected", 64'd1, 64'd0);
      else begin
        d = a_exp_q.pop_front(); due = a_due_q.pop_front();
        check("a_rdata", 64'(a_rdata_s), 64'(d));
        check("a_rvalid_cycle", 64'(cyc), 64'(due));
      end
    end else if (a_due_q.size() != 0 && a_due_q[0] == cyc) begin
      check("a_rvalid_missing", 64'd0, 64'd1);
      d = a_exp_q.pop_front(); due = a_due_q.pop_front();
    end
    if (b_rvalid_s) begin
      if (b_exp_q.size() == 0) check("b_rvalid_unexpected", 64'd1, 64'd0);
      else begin
        d = b_exp_q.pop_front(); due = b_due_q.pop_front();
        check("b_rdata", 64'(b_rdata_s), 64'(d));
        check("b_rvalid_cycle", 64'(cyc), 64'(due));
      end
    end else if (b_due_q.size() != 0 && b_due_q[0] == cyc) begin
      check("b_rvalid_missing", 64'd0, 64'd1);
      d = b_exp_q.pop_front(); due = b_due_q.pop_front();
    end
    if (a_ack_r) begin
      grant_log.push_back(1'b1);
      if (wr_q.size() == 0) check("ack_r_unrequested", 64'd1, 64'd0);
      else begin
        w = wr_q.pop_front();
        check("wr_addr", 64'(a_mem_addr), 64'(w.addr));
        check("wr_data", 64'(a_writedata), 64'(w.data));
        check("wr_strobes", 64'({a_write, a_read, a_chipselect}), 64'(3'b101));
      end
    end
    if (a_ack_s) begin
      grant_log.push_back(1'b0);
      if (rd_q.size() == 0) check("ack_s_unrequested", 64'd1, 64'd0);
      else begin
        ra = rd_q.pop_front();
        check("rd_addr", 64'(a_mem_addr), 64'(ra));
        check("rd_strobes", 64'({a_write, a_read, a_chipselect}), 64'(3'b011));
        a_exp_q.push_back(mem_word(ra));
        a_due_q.push_back(cyc + 1);
      end
    end
    if (b_ack_s) begin
      b_exp_q.push_back(mem_word(ra));
      b_due_q.push_back(cyc + 2);
    end
    drive_reqs();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int used;
    logic [31:0] exp_wr, exp_rd, exp_wait;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_strobes", 64'({a_write, a_read, a_chipselect, a_ack_s, a_ack_r, a_rvalid_s}), 64'd0);
    check("rst_mem_addr", 64'(a_mem_addr), 64'd0);
    check("rst_writedata", 64'(a_writedata), 64'd0);
    check("rst_rdata", 64'(a_rdata_s), 64'd0);
    check("rst_state", 64'(a_dbg_state), 64'(IDLE));
    check("rst_b_outputs", 64'(|{b_write, b_read, b_chipselect, b_ack_s, b_ack_r, b_rvalid_s,
                                 b_mem_addr, b_writedata, b_rdata_s, b_dbg_state,
                                 b_stat_wr, b_stat_rd, b_stat_wait}), 64'd0);
    reset = 1'b0;
    run_cycle(1'b0);
    check("idle_no_cmd", 64'({a_write, a_read, a_ack_r, a_ack_s}), 64'd0);

    // Single write
    wr_q.push_back('{addr: 20'h00100, data: 32'hDEADBEEF});
    drive_reqs();
    run_cycle(1'b0);
    check("wr1_ack", 64'(a_ack_r), 64'd1);
    run_cycle(1'b0);
    check("wr1_then_idle", 64'({a_write, a_read, a_chipselect, a_ack_r}), 64'd0);
    check("wr1_state", 64'(a_dbg_state), 64'(IDLE));

    // Single read, 0x12345678 back after 1 (a) and 2 (b) cycles
    rd_q.push_back(20'h00200);
    drive_reqs();
    run_cycle(1'b0);
    check("rd1_ack", 64'(a_ack_s), 64'd1);
    run_cycle(1'b0);
    check("rd1_a_rvalid", 64'(a_rvalid_s), 64'd1);
    check("rd1_a_rdata", 64'(a_rdata_s), 64'h12345678);
    run_cycle(1'b0);
    check("rd1_b_rdata", 64'(b_rdata_s), 64'h12345678);

    // Write held by 3 wait states
    wr_q.push_back('{addr: 20'h00300, data: 32'hCAFEF00D});
    drive_reqs();
    for (int i = 0; i < 4; i++) begin
      run_cycle(i < 3);
      check("wait_bus_held", 64'({a_write, a_mem_addr, a_writedata}),
            64'({1'b1, 20'h00300, 32'hCAFEF00D}));
      check("wait_ack_r", 64'(a_ack_r), 64'(i == 3));
    end
`ifdef MEM_ARB_STATS_EN
    exp_wait = 32'd3;
`else
    exp_wait = 32'd0;
`endif
    check("wait_stat", 64'(a_stat_wait), 64'(exp_wait));
    run_cycle(1'b0);

    // Contention: 17 writes and 2 reads from a common start -> W x8, R, W x8, R, W
    grant_log.delete();
    for (int i = 0; i < 17; i++) wr_q.push_back('{addr: 20'h01000 + 20'(i), data: 32'hA0000000 + 32'(i)});
    rd_q.push_back(20'h02000);
    rd_q.push_back(20'h02001);
    drive_reqs();
    used = 0;
    for (int k = 0; k < 60 && (wr_q.size() != 0 || rd_q.size() != 0); k++) begin
      run_cycle(1'b0);
      used++;
    end
    check("cont_drained", 64'(wr_q.size() + rd_q.size()), 64'd0);
    check("cont_cycles", 64'(used), 64'd19);
    check("cont_grants", 64'(grant_log.size()), 64'd19);
    for (int i = 0; i < grant_log.size() && i < 19; i++)
      check($sformatf("cont_grant_%0d", i), 64'(grant_log[i]), 64'(!(i == 8 || i == 17)));

    // Back-to-back reads, in-order returns
    for (int i = 0; i < 4; i++) rd_q.push_back(20'h00400 + 20'(i));
    drive_reqs();
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0);
      check("b2b_ack_s", 64'(a_ack_s), 64'd1);
    end
    repeat (4) run_cycle(1'b0);
    check("b2b_a_drained", 64'(a_exp_q.size()), 64'd0);
    check("b2b_b_drained", 64'(b_exp_q.size()), 64'd0);

`ifdef MEM_ARB_STATS_EN
    exp_wr = 32'd19; exp_rd = 32'd7;
`else
    exp_wr = 32'd0; exp_rd = 32'd0;
`endif
    check("stat_wr", 64'(a_stat_wr), 64'(exp_wr));
    check("stat_rd", 64'(a_stat_rd), 64'(exp_rd));

    // Reset the cycle after a read acceptance: b (latency 2) must not return it
    rd_q.push_back(20'h00500);
    drive_reqs();
    run_cycle(1'b0);
    check("rstrd_ack", 64'(a_ack_s), 64'd1);
    run_cycle(1'b0);
    reset = 1'b1;
    b_exp_q.delete();
    b_due_q.delete();
    run_cycle(1'b0);
    check("rstrd_b_no_rvalid", 64'(b_rvalid_s), 64'd0);
    check("rstrd_outputs", 64'({a_write, a_read, a_chipselect, a_ack_s, a_ack_r, a_rvalid_s,
                                b_rvalid_s, a_mem_addr}), 64'd0);
    check("rstrd_rdata", 64'(b_rdata_s), 64'd0);
    check("rstrd_stats", 64'(a_stat_wr | a_stat_rd | a_stat_wait), 64'd0);
    reset = 1'b0;
    repeat (3) begin
      run_cycle(1'b0);
      check("rstrd_b_quiet", 64'(b_rvalid_s), 64'd0);
    end

    check("final_a_queue", 64'(a_exp_q.size()), 64'd0);
    check("final_b_queue", 64'(b_exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
